// File: rtl/risc_sequencer.sv
// ---------------------------------------------------------------------------
// risc_sequencer
//
// Control sequencer for the accumulator RISC core. Every instruction passes
// through eight fixed phases. The sequencer decodes the current phase, the
// opcode and the ALU zero flag into the strobes that drive the datapath
// registers and the memory interface.
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous active-low reset (0 = reset)
//   opcode  opcode from the instruction register (valid from phase 3)
//   zero    accumulator-is-zero flag from the ALU
//   sel     address mux select (1 = PC, 0 = IR operand address)
//   rd      memory read enable
//   ld_ir   instruction register load
//   halt    processor halted
//   inc_pc  program counter increment
//   ld_ac   accumulator load
//   ld_pc   program counter load (jump)
//   wr      memory write enable
//   data_e  data bus drive enable (store)
//   phase   current phase (debug)
//
// The outputs are a combinational decode of the registered phase, so each
// strobe is valid in the same cycle as its phase. Because of that, an
// asynchronous reset removes every pulse of the abandoned instruction at once.
// ---------------------------------------------------------------------------
module risc_sequencer #(
  parameter int PHASE_WIDTH  = 3,
  parameter int OPCODE_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    zero,
  output logic                    sel,
  output logic                    rd,
  output logic                    ld_ir,
  output logic                    halt,
  output logic                    inc_pc,
  output logic                    ld_ac,
  output logic                    ld_pc,
  output logic                    wr,
  output logic                    data_e,
  output logic [PHASE_WIDTH-1:0]  phase
);

  typedef enum logic [PHASE_WIDTH-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_SKZ = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_STO = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(7);

  phase_t phase_reg;
  logic   halted_reg;

  // Opcode class decodes, shared by several phases.
  logic is_hlt;
  logic is_skz;
  logic is_sto;
  logic is_jmp;
  logic is_aluop;

  assign is_hlt   = (opcode == OP_HLT);
  assign is_skz   = (opcode == OP_SKZ);
  assign is_sto   = (opcode == OP_STO);
  assign is_jmp   = (opcode == OP_JMP);
  assign is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

  // The halting edge itself leaves the phase at OP_ADDR, so the core parks
  // on the phase that raised halt and stays there until reset.
  logic halt_now;
  assign halt_now = (phase_reg == OP_ADDR) && is_hlt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_reg  <= INST_ADDR;
      halted_reg <= 1'b0;
    end else if (halted_reg || halt_now) begin
      phase_reg  <= OP_ADDR;
      halted_reg <= 1'b1;
    end else begin
      phase_reg  <= phase_t'(phase_reg + 1'b1);
    end
  end

  assign phase = phase_reg;

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    halt   = 1'b0;
    inc_pc = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;

    if (halted_reg) begin
      // Parked: only the halt indication survives.
      halt = 1'b1;
    end else begin
      unique case (phase_reg)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = is_hlt;
        end
        OP_FETCH: begin
          rd = is_aluop;
        end
        ALU_OP: begin
          rd     = is_aluop;
          // zero matters only here and only for a skip instruction.
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        STORE: begin
          rd     = is_aluop;
          ld_ac  = is_aluop;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_risc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_risc_sequencer
//
// Directed bench for risc_sequencer. Expected output words are hand-written
// per phase, packed as {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e}.
// ---------------------------------------------------------------------------
module tb_risc_sequencer;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
  logic [2:0] phase;

  int n_cmp;
  int n_bad;

  risc_sequencer #(
    .PHASE_WIDTH  (3),
    .OPCODE_WIDTH (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .halt   (halt),
    .inc_pc (inc_pc),
    .ld_ac  (ld_ac),
    .ld_pc  (ld_pc),
    .wr     (wr),
    .data_e (data_e),
    .phase  (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] outs;
  assign outs = {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e};

  // Per-phase expectations, phase 0 in the low 9 bits.
  localparam logic [8:0] F0 = 9'b100000000;
  localparam logic [8:0] F1 = 9'b110000000;
  localparam logic [8:0] F2 = 9'b111000000;
  localparam logic [8:0] F3 = 9'b111000000;
  localparam logic [8:0] P4 = 9'b000010000;
  localparam logic [8:0] RD = 9'b010000000;
  localparam logic [8:0] NO = 9'b000000000;

  localparam logic [71:0] T_ALU  = {9'b010001000, RD, RD, P4, F3, F2, F1, F0};
  localparam logic [71:0] T_STO  = {9'b000000011, 9'b000000001, NO, P4, F3, F2, F1, F0};
  localparam logic [71:0] T_SKZ1 = {NO, 9'b000010000, NO, P4, F3, F2, F1, F0};
  localparam logic [71:0] T_SKZ0 = {NO, NO, NO, P4, F3, F2, F1, F0};
  localparam logic [71:0] T_JMP  = {9'b000000100, 9'b000000100, NO, P4, F3, F2, F1, F0};

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Runs phases 0..last of one instruction, starting at phase 0 just after
  // an edge. A junk opcode/zero is driven before they are meant to matter.
  // Ends just after the edge leaving phase 'last' when do_last_edge is set.
  task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                           input logic [71:0] tbl, input int last, input bit do_last_edge);
    opcode = ~op;
    zero   = ~z;
    for (int p = 0; p <= last; p++) begin
      if (p == 3) opcode = op;
      if (p == 6) zero = z;
      #1;
      check($sformatf("%s phase%0d", name, p), {6'd0, phase}, 9'(p));
      check($sformatf("%s outs%0d", name, p), outs, tbl[p*9 +: 9]);
      if (p < last || do_last_edge) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst    = 1'b0;
    opcode = 3'd2;
    zero   = 1'b0;

    // Reset holds phase 0 before and across clock edges.
    #2;
    check("reset phase", {6'd0, phase}, 9'd0);
    check("reset outs", outs, F0);
    @(posedge clk);
    #1;
    check("reset hold phase", {6'd0, phase}, 9'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("released phase", {6'd0, phase}, 9'd0);
    @(posedge clk);
    #1;
    check("first edge phase", {6'd0, phase}, 9'd1);
    // Park back on phase 0 via reset so the instructions start cleanly.
    rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("resync phase", {6'd0, phase}, 9'd1);
    for (int i = 0; i < 7; i++) @(posedge clk);
    #1;
    check("wrap to 0", {6'd0, phase}, 9'd0);

    // Back-to-back instructions; each run leaves the sequencer at phase 0.
    run_instr("ADD", 3'd2, 1'b0, T_ALU, 7, 1);
    run_instr("ADDz", 3'd2, 1'b1, T_ALU, 7, 1);
    run_instr("AND", 3'd3, 1'b0, T_ALU, 7, 1);
    run_instr("XOR", 3'd4, 1'b1, T_ALU, 7, 1);
    run_instr("LDA", 3'd5, 1'b0, T_ALU, 7, 1);
    run_instr("STO", 3'd6, 1'b0, T_STO, 7, 1);
    run_instr("SKZ1", 3'd1, 1'b1, T_SKZ1, 7, 1);
    run_instr("SKZ0", 3'd1, 1'b0, T_SKZ0, 7, 1);
    run_instr("JMP", 3'd7, 1'b1, T_JMP, 7, 1);
    #1;
    check("after JMP phase", {6'd0, phase}, 9'd0);

    // Halt: phase 4 shows halt with inc_pc, then the core parks.
    run_instr("HLT", 3'd0, 1'b0, {NO, NO, NO, 9'b000110000, F3, F2, F1, F0}, 4, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) opcode = 3'd2;  // a changed opcode must not unpark the core
      check($sformatf("halted phase %0d", i), {6'd0, phase}, 9'd4);
      check($sformatf("halted outs %0d", i), outs, 9'b000100000);
      @(posedge clk);
      #1;
    end
    // Reset is the only way out.
    #2;
    rst = 1'b0;
    #1;
    check("halt reset phase", {6'd0, phase}, 9'd0);
    check("halt reset outs", outs, F0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post-halt count", {6'd0, phase}, 9'd1);
    for (int i = 0; i < 7; i++) @(posedge clk);
    #1;

    // Asynchronous reset mid-cycle during a store's write phase.
    run_instr("STOr", 3'd6, 1'b0, T_STO, 7, 0);
    #2;
    rst = 1'b0;
    #1;
    check("async rst phase", {6'd0, phase}, 9'd0);
    check("async rst outs", outs, F0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("async rst resume", {6'd0, phase}, 9'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/risc_sequencer.md
Name: risc_sequencer

Overview:
- Control sequencer for the accumulator RISC core.
- Steps every instruction through 8 fixed phases.
- Drives the load/enable strobes for the datapath registers (IR, AC, PC), the address mux select, and the memory read/write/bus enables.
- Sits directly upstream of the datapath registers: its ld_* outputs are their load inputs.

Parameters:
- PHASE_WIDTH, 3, width of the internal phase counter (8 phases; fixed by the ISA, not meant to be changed).
- OPCODE_WIDTH, 3, width of the opcode field from the instruction register.

Ports:
- clk     input   1  rising-edge clock.
- rst     input   1  asynchronous, active-low reset (0 = reset).
- opcode  input   3  opcode from the instruction register. Valid from phase 3 onward.
- zero    input   1  accumulator-is-zero flag from the ALU.
- sel     output  1  address mux select (1 = PC, 0 = IR operand address).
- rd      output  1  memory read enable.
- ld_ir   output  1  instruction register load.
- halt    output  1  processor halted.
- inc_pc  output  1  program counter increment.
- ld_ac   output  1  accumulator load.
- ld_pc   output  1  program counter load (jump).
- wr      output  1  memory write enable.
- data_e  output  1  data bus drive enable (store).
- phase   output  3  current phase, for debug and the bench.

Behaviour:
- Opcode encoding: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALUOP = ADD, AND, XOR or LDA.
- Phase register: 3 bits, increments by 1 each clk rising edge, wraps 7 -> 0.
- Outputs: purely combinational decode of the registered phase, opcode and zero. No added latency; an output is valid in the same cycle as its phase.
- Outputs not listed for a phase are 0. Phase decode:
  - 0 INST_ADDR: sel=1.
  - 1 INST_FETCH: sel=1, rd=1.
  - 2 INST_LOAD: sel=1, rd=1, ld_ir=1.
  - 3 IDLE: sel=1, rd=1, ld_ir=1.
  - 4 OP_ADDR: inc_pc=1; halt=1 if opcode==HLT.
  - 5 OP_FETCH: rd=ALUOP.
  - 6 ALU_OP: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
  - 7 STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO).
- Halt:
  - On a rising edge in phase 4 with opcode==HLT, a sticky halted flag sets.
  - While halted: phase frozen at 4, halt=1, all other outputs 0 (inc_pc suppressed).
  - Only reset clears the halted flag.
- Reset (rst=0, asynchronous):
  - Phase=0 and halted=0 immediately, regardless of clk.
  - During reset, outputs reflect phase 0: sel=1, all others 0.
  - Counting resumes on the first rising edge after rst returns to 1; that edge moves the phase to 1.
- Mid-instruction reset: abandons the instruction. No further wr, ld_ac or ld_pc pulses for it.
- zero is sampled only in phase 6 and only for SKZ. It is ignored for all other opcodes and phases.
- Opcode changes outside phases 4–7 have no effect on the ld_ac, ld_pc, wr, data_e or halt outputs.
- Unknown (X/Z) opcode in phases 4–7 is a usage error. Any assigned value is acceptable (no requirement).

Test Plan:
- Reset, then run 8 edges with opcode=ADD, zero=0 -> phase sequence 0..7,0; ld_ir=1 only in phases 2–3; inc_pc=1 only in phase 4; rd=1 in phases 5–7; ld_ac=1 only in phase 7; wr=0 throughout.
- opcode=STO -> phase 6: data_e=1, wr=0; phase 7: data_e=1, wr=1, ld_ac=0, rd=0.
- opcode=SKZ -> with zero=1, inc_pc=1 in phases 4 and 6; with zero=0, inc_pc=1 only in phase 4.
- opcode=JMP -> ld_pc=1 in phases 6 and 7; rd=0 and ld_ac=0 in phases 5–7.
- opcode=HLT -> halt=1 at phase 4; after 10 more edges, phase stays 4, halt=1, inc_pc=0. Then pulse rst=0 -> phase=0, halt=0, sel=1.
- Assert rst=0 asynchronously mid-cycle in phase 7 with opcode=STO -> wr and data_e drop to 0 immediately, phase=0 without waiting for a clk edge.
